// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - Shared states and default sizes for the program loader.
// Contents: state_e loader state encoding; DEF_INSTR_SIZE, DEF_ADDR_SIZE and
// DEF_PROGRAM_SIZE defaults shared with the CPU top.
// Configuration macro: PROG_LOADER_CHECKSUM_EN adds the ST_CHK state.
package prog_loader_pkg;

    localparam int DEF_INSTR_SIZE   = 12;
    localparam int DEF_ADDR_SIZE    = 5;
    localparam int DEF_PROGRAM_SIZE = 16;

    typedef enum logic [2:0] {
        ST_COUNT,
        ST_HI,
        ST_LO,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_FILL,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - Byte-stream program loader that fills CPU program memory.
// Ports: clk, rst (async, active high); in_valid/in_data/in_ready host byte stream;
// reload restarts from DONE or ERR; mem_we/mem_addr/mem_wdata program memory write
// port; cpu_hold stalls the CPU; load_done and load_err report the final status.
// Configuration macro: PROG_LOADER_CHECKSUM_EN appends an XOR checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int INSTR_SIZE   = DEF_INSTR_SIZE,
    parameter int ADDR_SIZE    = DEF_ADDR_SIZE,
    parameter int PROGRAM_SIZE = DEF_PROGRAM_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  mem_we,
    output logic [ADDR_SIZE-1:0]  mem_addr,
    output logic [INSTR_SIZE-1:0] mem_wdata,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int         HI_W    = INSTR_SIZE - 8;
    // Bits of the HI byte that may legally be set.
    localparam logic [7:0] HI_MASK = 8'((1 << HI_W) - 1);
    localparam logic [7:0] PSZ     = 8'(PROGRAM_SIZE);

    state_e                  state_q;
    logic [7:0]              n_q;
    logic [7:0]              idx_q;
    logic [HI_W-1:0]         hi_q;
    logic                    mem_we_q;
    logic [ADDR_SIZE-1:0]    mem_addr_q;
    logic [INSTR_SIZE-1:0]   mem_wdata_q;
    logic                    cpu_hold_q;
    logic                    load_done_q;
    logic                    load_err_q;
    logic                    xfer;
    logic [INSTR_SIZE-1:0]   word_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]              chk_q;
    logic [7:0]              chk_d;
    assign chk_d = chk_q ^ in_data;
`endif

    // in_ready is decoded from state so a byte can be taken in the first
    // cycle of a receiving state; it is forced low while reset is held.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_COUNT, ST_HI, ST_LO: in_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CHK:                 in_ready = 1'b1;
`endif
                default:                in_ready = 1'b0;
            endcase
        end
    end

    assign xfer   = in_valid && in_ready;
    assign word_d = {hi_q, in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_COUNT;
            n_q         <= '0;
            idx_q       <= '0;
            hi_q        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                ST_COUNT: if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_q <= in_data;
`endif
                    if (in_data == 8'd0 || in_data > PSZ) begin
                        state_q    <= ST_ERR;
                        load_err_q <= 1'b1;
                    end else begin
                        n_q     <= in_data;
                        idx_q   <= '0;
                        state_q <= ST_HI;
                    end
                end
                ST_HI: if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_q <= chk_d;
`endif
                    if ((in_data & ~HI_MASK) != 8'd0) begin
                        state_q    <= ST_ERR;
                        load_err_q <= 1'b1;
                    end else begin
                        hi_q    <= in_data[HI_W-1:0];
                        state_q <= ST_LO;
                    end
                end
                ST_LO: if (xfer) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    chk_q <= chk_d;
`endif
                    mem_we_q    <= 1'b1;
                    mem_addr_q  <= ADDR_SIZE'(idx_q);
                    mem_wdata_q <= word_d;
                    idx_q       <= idx_q + 8'd1;
                    if (idx_q == n_q - 8'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_q <= ST_CHK;
`else
                        state_q <= ST_FILL;
`endif
                    end else begin
                        state_q <= ST_HI;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                ST_CHK: if (xfer) begin
                    if (in_data == chk_q) begin
                        state_q <= ST_FILL;
                    end else begin
                        state_q    <= ST_ERR;
                        load_err_q <= 1'b1;
                    end
                end
`endif
                // idx_q continues from N, so unused slots are zeroed in order.
                ST_FILL: begin
                    if (idx_q < PSZ) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= ADDR_SIZE'(idx_q);
                        mem_wdata_q <= '0;
                        idx_q       <= idx_q + 8'd1;
                    end else begin
                        state_q     <= ST_DONE;
                        cpu_hold_q  <= 1'b0;
                        load_done_q <= 1'b1;
                    end
                end
                ST_DONE, ST_ERR: if (reload) begin
                    state_q     <= ST_COUNT;
                    cpu_hold_q  <= 1'b1;
                    load_done_q <= 1'b0;
                    load_err_q  <= 1'b0;
                end
                default: state_q <= ST_COUNT;
            endcase
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - Directed vector bench for prog_loader (either macro setting).
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [11:0] mem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    prog_loader #(.INSTR_SIZE(12), .ADDR_SIZE(5), .PROGRAM_SIZE(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .reload(reload), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nb;
        logic [63:0] stream;   // byte i at [63-8*i -: 8]
        bit          done;
        bit          err;
        int          nwr;
        logic [15:0] w0;
        logic [15:0] w1;
    } vec_t;

    vec_t        vecs[8];
    int          nv = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    int          viol = 0;
    logic [15:0] tbmem[32];

    // Write monitor: every strobe is one cycle wide, so one negedge sees it.
    always @(negedge clk) begin
        if (mem_we) begin
            tbmem[mem_addr] = {4'h0, mem_wdata};
            wr_cnt = wr_cnt + 1;
            if (load_done || load_err || !cpu_hold) viol = viol + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input int nb, input logic [63:0] s, input bit d, input bit e,
                           input int nwr, input logic [15:0] w0, input logic [15:0] w1);
        vecs[nv].nb = nb; vecs[nv].stream = s; vecs[nv].done = d; vecs[nv].err = e;
        vecs[nv].nwr = nwr; vecs[nv].w0 = w0; vecs[nv].w1 = w1;
        nv++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; reload = 1'b0;
        #1;
        check("reset_ctl", 32'({in_ready, cpu_hold, mem_we, load_done, load_err}), 32'h08);
        check("reset_mem", 32'({mem_addr, mem_wdata}), 32'h0);
        for (int i = 0; i < 32; i++) tbmem[i] = 16'hDEAD;
        wr_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = b;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        ok = in_ready;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(load_done || load_err) && t < 60) begin
            @(negedge clk);
            t++;
        end
    endtask

    initial begin
        bit          ok;
        bit          all_ok;
        bit          mbad;
        logic [15:0] e;
        logic [7:0]  x;

        add_vec(1, {8'h00, 56'h0}, 1'b0, 1'b1, 0, 16'h0, 16'h0);
        add_vec(1, {8'h11, 56'h0}, 1'b0, 1'b1, 0, 16'h0, 16'h0);
        add_vec(4, {8'h02, 8'h0A, 8'h05, 8'h1A, 32'h0}, 1'b0, 1'b1, 1, 16'h0A05, 16'h0);
`ifdef PROG_LOADER_CHECKSUM_EN
        add_vec(6, {8'h02, 8'h0A, 8'h05, 8'h0C, 8'h11, 8'h10, 16'h0}, 1'b1, 1'b0, 16, 16'h0A05, 16'h0C11);
        add_vec(4, {8'h01, 8'h0F, 8'hFF, 8'hF1, 32'h0}, 1'b1, 1'b0, 16, 16'h0FFF, 16'h0);
        add_vec(4, {8'h01, 8'h0A, 8'h05, 8'h0E, 32'h0}, 1'b1, 1'b0, 16, 16'h0A05, 16'h0);
        add_vec(4, {8'h01, 8'h0A, 8'h05, 8'h0F, 32'h0}, 1'b0, 1'b1, 1, 16'h0A05, 16'h0);
`else
        add_vec(5, {8'h02, 8'h0A, 8'h05, 8'h0C, 8'h11, 24'h0}, 1'b1, 1'b0, 16, 16'h0A05, 16'h0C11);
        add_vec(3, {8'h01, 8'h0F, 8'hFF, 40'h0}, 1'b1, 1'b0, 16, 16'h0FFF, 16'h0);
`endif

        for (int v = 0; v < nv; v++) begin
            do_reset();
            all_ok = 1'b1;
            for (int i = 0; i < vecs[v].nb; i++) begin
                send_byte(vecs[v].stream[63-8*i -: 8], ok);
                all_ok = all_ok & ok;
            end
            check($sformatf("v%0d_accept", v), 32'(all_ok), 32'h1);
            wait_end();
            check($sformatf("v%0d_status", v), 32'({load_done, load_err, cpu_hold}),
                  32'({vecs[v].done, vecs[v].err, ~vecs[v].done}));
            check($sformatf("v%0d_writes", v), 32'(wr_cnt), 32'(vecs[v].nwr));
            mbad = 1'b0;
            for (int a = 0; a < 16; a++) begin
                e = (a >= vecs[v].nwr) ? 16'hDEAD : (a == 0) ? vecs[v].w0 :
                    (a == 1) ? vecs[v].w1 : 16'h0;
                if (tbmem[a] !== e) mbad = 1'b1;
            end
            check($sformatf("v%0d_mem", v), 32'(mbad), 32'h0);
        end

        // Error, in_ready low in ERR, then reload back to COUNT.
        do_reset();
        send_byte(8'h11, ok);
        wait_end();
        check("err_ready_low", 32'({load_err, in_ready}), 32'h2);
        @(negedge clk); reload = 1'b1;
        @(negedge clk); reload = 1'b0;
        check("reload_count", 32'({load_err, cpu_hold, in_ready}), 32'h3);
        check("reload_nowrite", 32'(wr_cnt), 32'h0);

        // Full program of 16 words with in_valid low between bytes.
        do_reset();
        x = 8'h10;
        send_byte(8'h10, ok);
        all_ok = ok;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            send_byte(8'(i), ok);
            all_ok = all_ok & ok;
            x = x ^ 8'(i);
            @(negedge clk);
            send_byte(8'(i * 17), ok);
            all_ok = all_ok & ok;
            x = x ^ 8'(i * 17);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(x, ok);
        all_ok = all_ok & ok;
`endif
        check("full_accept", 32'(all_ok), 32'h1);
        @(negedge clk);
        check("full_fill_cycle", 32'({load_done, cpu_hold}), 32'h1);
        @(negedge clk);
        check("full_done", 32'({load_done, cpu_hold}), 32'h2);
        check("full_writes", 32'(wr_cnt), 32'd16);
        mbad = 1'b0;
        for (int a = 0; a < 16; a++)
            if (tbmem[a] !== {4'h0, 4'(a), 8'(a * 17)}) mbad = 1'b1;
        check("full_mem", 32'(mbad), 32'h0);

        // Reset between HI and LO of the second word.
        do_reset();
        send_byte(8'h02, ok);
        send_byte(8'h0A, ok);
        send_byte(8'h05, ok);
        send_byte(8'h0C, ok);
        #2 rst = 1'b1;
        #1 check("midrst_state", 32'({cpu_hold, in_ready, load_done, mem_we}), 32'h8);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_nowrite", 32'(wr_cnt), 32'h1);
        check("midrst_keep", 32'({tbmem[0], tbmem[1]}), 32'h0A05DEAD);
        send_byte(8'h01, ok);
        send_byte(8'h03, ok);
        send_byte(8'h04, ok);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h06, ok);
`endif
        wait_end();
        check("midrst_reload", 32'({load_done, tbmem[0], tbmem[1]}), 32'({1'b1, 16'h0304, 16'h0}));

        check("we_outside_load", 32'(viol), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter INSTR_SIZE, default 12, instruction word width; legal range 9..16.
REQ-002 Parameter ADDR_SIZE, default 5, program memory address width.
REQ-003 Parameter PROGRAM_SIZE, default 16, number of program slots loaded or zero-filled; PROGRAM_SIZE <= 2**ADDR_SIZE and <= 255.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  host byte valid.
REQ-007 in_data  in  8  host byte.
REQ-008 in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
REQ-009 reload  in  1  single-cycle request to start a new load from DONE or ERR.
REQ-010 mem_we  out  1  program memory write strobe.
REQ-011 mem_addr  out  ADDR_SIZE  program memory write address.
REQ-012 mem_wdata  out  INSTR_SIZE  program memory write data.
REQ-013 cpu_hold  out  1  keeps the CPU halted while high.
REQ-014 load_done  out  1  level, program loaded and CPU released.
REQ-015 load_err  out  1  level, load aborted on a format or checksum error.

Function
REQ-016 States: COUNT, HI, LO, CHK (macro only), FILL, DONE, ERR.
REQ-017 in_ready is high only in COUNT, HI, LO and CHK.
REQ-018 COUNT: the accepted byte is word count N; N = 0 or N > PROGRAM_SIZE -> ERR; otherwise store N, clear word index, -> HI.
REQ-019 HI: accepted byte bits [INSTR_SIZE-9:0] form word bits [INSTR_SIZE-1:8]; any nonzero higher bit -> ERR; otherwise -> LO.
REQ-020 LO: accepted byte forms word bits [7:0].
REQ-021 The cycle after LO acceptance: mem_we = 1 for exactly one cycle, mem_addr = word index, mem_wdata = assembled word; word index increments.
REQ-022 After the LO byte of word N-1, go to CHK if the macro is defined, else to FILL; otherwise -> HI.
REQ-023 FILL: one write per cycle of mem_wdata = 0 to addresses N..PROGRAM_SIZE-1; if N = PROGRAM_SIZE, FILL lasts one cycle and performs no write.
REQ-024 The cycle after the last FILL write (or the empty FILL cycle) -> DONE: cpu_hold = 0, load_done = 1.
REQ-025 ERR: cpu_hold = 1, load_err = 1, no memory writes.
REQ-026 reload is sampled only in DONE and ERR; it goes to COUNT and, in the next cycle, sets cpu_hold = 1 and clears load_done and load_err; in all other states it is ignored.
REQ-027 Cycles with in_valid low in HI, LO or CHK stall without timeout; state and partial word are held.
REQ-028 mem_we is never high in COUNT, DONE or ERR.

Reset
REQ-029 On rst high, regardless of clock: state = COUNT, cpu_hold = 1, in_ready = 0 while rst is asserted, mem_we = 0, mem_addr = 0, mem_wdata = 0, load_done = 0, load_err = 0, word index = 0, checksum = 0.
REQ-030 Reset mid-load abandons the partial program; words already written are not cleared.

Configuration
REQ-031 With PROG_LOADER_CHECKSUM_EN defined: the running XOR of all accepted bytes from the count byte onward is kept; in CHK, the accepted byte must equal that XOR -> FILL, else -> ERR.
REQ-032 Without PROG_LOADER_CHECKSUM_EN: there is no CHK state and no checksum register; LO of the last word goes directly to FILL.

Structure
REQ-033 Package prog_loader_pkg holds the state enumeration and the default INSTR_SIZE, ADDR_SIZE and PROGRAM_SIZE constants shared with the CPU top.
REQ-034 The block is a single module with no sub-module; the CPU top wires mem_* to its memory write port and cpu_hold to the CPU stall input.

Verification
REQ-035 Bytes 0x02,0x0A,0x05,0x0C,0x11 (macro off) -> writes [0]=0xA05, [1]=0xC11, [2..15]=0, then load_done=1, cpu_hold=0.
REQ-036 Count 0x00 or 0x11 -> ERR, load_err=1, no mem_we; then reload -> COUNT with load_err=0.
REQ-037 HI byte 0x1A -> ERR; words before it keep their written values.
REQ-038 Macro on, bytes 0x01,0x0A,0x05,0x0E -> DONE; same stream with checksum 0x0F -> ERR.
REQ-039 Count 0x10 with 16 words, in_valid toggled every other cycle -> 16 writes, a one-cycle FILL with no write, then DONE.
REQ-040 rst pulsed between the HI and LO bytes -> COUNT, cpu_hold=1, and no write of the partial word.
